// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared state encoding and default word width for the serial link
package fsm_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/fsm_serializer.sv
// rtl/fsm_serializer.sv - parallel-to-serial transmitter; FSM_SERIALIZER_PARITY_EN appends an even parity bit
module fsm_serializer
    import fsm_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
`ifdef FSM_SERIALIZER_PARITY_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
`else
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
`endif

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_q, out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] shifted;
`ifdef FSM_SERIALIZER_PARITY_EN
    logic              par_q, par_d;
`endif

    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    // Zero-fill shift toward whichever end feeds the line.
    assign shifted = MSB_FIRST ? {shreg_q[DATA_W-2:0], 1'b0} : {1'b0, shreg_q[DATA_W-1:1]};

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        out_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef FSM_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (start) begin
                    shreg_d = din;
                    out_d   = head_bit(din);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
`ifdef FSM_SERIALIZER_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    shreg_d = shifted;
                    out_d   = head_bit(shifted);
                    cnt_d   = cnt_q + CNT_W'(1);
`ifdef FSM_SERIALIZER_PARITY_EN
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        out_d = par_q;
                    end
`endif
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FSM_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FSM_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_fsm_serializer.sv
// tb/tb_fsm_serializer.sv - self-checking bench for fsm_serializer (MSB-first and LSB-first instances)
module tb_fsm_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_m = 1'b0, start_l = 1'b0;
    logic [7:0] din_m = 8'h00, din_l = 8'h00;
    logic       out_m, busy_m, done_m;
    logic       out_l, busy_l, done_l;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    fsm_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .start(start_m), .din(din_m),
        .out(out_m), .busy(busy_m), .done(done_m)
    );

    fsm_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .start(start_l), .din(din_l),
        .out(out_l), .busy(busy_l), .done(done_l)
    );

    // Reference: a frame is a list of line bits; each edge either starts a list,
    // emits its next bit, or, once it is exhausted, emits the done pulse.
    bit mf   [2][16];
    int mlen [2];
    int mpos [2];
    bit mout [2];
    bit mbusy[2];
    bit mdone[2];

    typedef struct {
        bit         sel;
        bit         st;
        logic [7:0] d;
        logic [2:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: out/busy/done got %b expected %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mlen[i] = 0; mpos[i] = 0;
            mout[i] = 1'b0; mbusy[i] = 1'b0; mdone[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int i, input bit s, input logic [7:0] w);
        if (!mbusy[i]) begin
            mdone[i] = 1'b0;
            mout[i]  = 1'b0;
            if (s) begin
                for (int k = 0; k < 8; k++) mf[i][k] = (i == 0) ? w[7-k] : w[k];
                mlen[i] = 8;
`ifdef FSM_SERIALIZER_PARITY_EN
                mf[i][8] = ^w;
                mlen[i]  = 9;
`endif
                mout[i]  = mf[i][0];
                mpos[i]  = 1;
                mbusy[i] = 1'b1;
            end
        end else if (mpos[i] < mlen[i]) begin
            mout[i] = mf[i][mpos[i]];
            mpos[i]++;
        end else begin
            mout[i]  = 1'b0;
            mbusy[i] = 1'b0;
            mdone[i] = 1'b1;
        end
    endtask

    task automatic check_model();
        chk("model_msb", {out_m, busy_m, done_m}, {mout[0], mbusy[0], mdone[0]});
        chk("model_lsb", {out_l, busy_l, done_l}, {mout[1], mbusy[1], mdone[1]});
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_msb"}, {out_m, busy_m, done_m}, 3'b000);
        chk({nm, "_lsb"}, {out_l, busy_l, done_l}, 3'b000);
    endtask

    // Called just after a falling edge: drive, clock, then sample on the next falling edge.
    task automatic step(input bit s0, input logic [7:0] d0, input bit s1, input logic [7:0] d1);
        start_m = s0; din_m = d0;
        start_l = s1; din_l = d1;
        @(posedge clk);
        model_edge(0, s0, d0);
        model_edge(1, s1, d1);
        @(negedge clk);
        check_model();
    endtask

    task automatic step_both(input bit s, input logic [7:0] d);
        step(s, d, s, d);
    endtask

    function automatic void add(input bit sel, input bit st, input logic [7:0] d, input logic [2:0] exp);
        tbl.push_back('{sel, st, d, exp});
    endfunction

    initial begin
`ifdef FSM_SERIALIZER_PARITY_EN
        add(0, 1, 8'hA7, 3'b110); add(0, 0, 8'h00, 3'b010); add(0, 0, 8'h00, 3'b110);
        add(0, 0, 8'h00, 3'b010); add(0, 0, 8'h00, 3'b010); add(0, 0, 8'h00, 3'b110);
        add(0, 0, 8'h00, 3'b110); add(0, 0, 8'h00, 3'b110); add(0, 0, 8'h00, 3'b110);
        add(0, 0, 8'h00, 3'b001); add(0, 0, 8'h00, 3'b000);
`else
        add(0, 1, 8'hB2, 3'b110); add(0, 0, 8'h00, 3'b010); add(0, 0, 8'h00, 3'b110);
        add(0, 0, 8'h00, 3'b110); add(0, 0, 8'h00, 3'b010); add(0, 0, 8'h00, 3'b010);
        add(0, 0, 8'h00, 3'b110); add(0, 0, 8'h00, 3'b010); add(0, 0, 8'h00, 3'b001);
        add(0, 0, 8'h00, 3'b000);
        add(1, 1, 8'h01, 3'b110); add(1, 0, 8'hFF, 3'b010); add(1, 0, 8'h00, 3'b010);
        add(1, 0, 8'h00, 3'b010); add(1, 0, 8'h00, 3'b010); add(1, 0, 8'h00, 3'b010);
        add(1, 0, 8'h00, 3'b010); add(1, 0, 8'h00, 3'b010); add(1, 0, 8'h00, 3'b001);
        add(1, 0, 8'h00, 3'b000);
`endif

        model_reset();
        @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;
        for (int c = 0; c < 20; c++) step_both(1'b0, 8'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].sel) step(1'b0, 8'h00, tbl[i].st, tbl[i].d);
            else            step(tbl[i].st, tbl[i].d, 1'b0, 8'h00);
            chk($sformatf("table[%0d]", i),
                tbl[i].sel ? {out_l, busy_l, done_l} : {out_m, busy_m, done_m}, tbl[i].exp);
        end

        // start/din changes during SHIFT must not disturb the frame
        step_both(1'b1, 8'hF0);
        for (int c = 0; c < 3; c++) step_both(1'b0, 8'h00);
        for (int c = 0; c < 4; c++) step_both(1'b1, 8'h0F);
        for (int c = 0; c < 16; c++) step_both(1'b0, 8'h00);

        // back-to-back frames with start held high through DONE
        step_both(1'b1, 8'hA5);
        for (int c = 0; c < 12; c++) step_both(1'b1, 8'h3C);
        for (int c = 0; c < 12; c++) step_both(1'b0, 8'h00);

        // asynchronous reset mid-frame, overlapping a start request
        step_both(1'b1, 8'hFF);
        for (int c = 0; c < 4; c++) step_both(1'b0, 8'h00);
        #2 reset = 1'b1;
        start_m = 1'b1; start_l = 1'b1;
        #1 check_zero("async_reset");
        model_reset();
        @(negedge clk);
        check_zero("reset_with_start");
        reset = 1'b0;
        step_both(1'b0, 8'h00);
        step_both(1'b1, 8'h5A);
        for (int c = 0; c < 11; c++) step_both(1'b0, 8'h00);

        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 3) == 0), 8'($urandom),
                 ($urandom_range(0, 3) == 0), 8'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                #3 reset = 1'b1;
                #1 check_zero("rand_reset");
                model_reset();
                @(negedge clk);
                reset = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
